// File: rtl/pattern_matcher_pkg.sv
// Shared definitions for the laser receive-path pattern matcher:
// link sequences, handshake byte, default parameters and the lane progress type.
package pattern_matcher_pkg;

  localparam int DEF_NUM_SEQ     = 4;
  localparam int DEF_SEQ_BYTES   = 4;
  localparam int DEF_BYTE_W      = 8;
  localparam int DEF_GAP_TIMEOUT = 64;

  localparam logic [31:0] SEQ_START = 32'hc1c2c3c4;
  localparam logic [31:0] SEQ_STOP  = 32'h51525354;
  localparam logic [31:0] SEQ_DATA  = 32'hd1d2d3d4;
  localparam logic [31:0] SEQ_ACK   = 32'ha1a2a3a4;

  localparam logic [7:0] HANDSHAKE_BYTE = 8'h55;

  // Wide enough for the longest supported pattern (8 bytes -> progress 0..7)
  localparam int PROG_W = 3;
  typedef logic [PROG_W-1:0] prog_t;

  typedef enum logic [1:0] {
    LINK_START,
    LINK_STOP,
    LINK_DATA,
    LINK_ACK
  } link_id_t;

  function automatic logic [31:0] link_seq(input link_id_t id);
    logic [31:0] value;
    case (id)
      LINK_START: value = SEQ_START;
      LINK_STOP:  value = SEQ_STOP;
      LINK_DATA:  value = SEQ_DATA;
      default:    value = SEQ_ACK;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/pattern_matcher_lane.sv
// One pattern lane: progress register, expected-byte select, restart-on-mismatch
// and a combinational completion strobe registered by the top.
module pattern_lane
  import pattern_matcher_pkg::*;
#(
  parameter int SEQ_BYTES = DEF_SEQ_BYTES,
  parameter int BYTE_W    = DEF_BYTE_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        accept,
  input  logic                        flush,
  input  logic [BYTE_W-1:0]           data_in,
  input  logic [SEQ_BYTES*BYTE_W-1:0] pattern,
  output logic                        complete,
  output logic                        active_next
);

  localparam prog_t LAST = prog_t'(SEQ_BYTES - 1);

  prog_t             progress;
  prog_t             progress_next;
  logic [BYTE_W-1:0] expected;
  logic [BYTE_W-1:0] first_byte;

  assign first_byte = pattern[SEQ_BYTES*BYTE_W-1 -: BYTE_W];

  // Byte 0 of the pattern is the most-significant byte
  always_comb begin
    expected = '0;
    for (int k = 0; k < SEQ_BYTES; k++) begin
      if (progress == prog_t'(k)) begin
        expected = pattern[(SEQ_BYTES-1-k)*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    progress_next = progress;
    complete      = 1'b0;
    if (!enable || flush) begin
      progress_next = '0;
    end else if (accept) begin
      if (data_in == expected) begin
        if (progress == LAST) begin
          progress_next = '0;
          complete      = 1'b1;
        end else begin
          progress_next = progress + prog_t'(1);
        end
      end else begin
        // A mismatching byte may itself be the start of a fresh attempt
        progress_next = (data_in == first_byte) ? prog_t'(1) : '0;
      end
    end
  end

  assign active_next = (progress_next != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      progress <= '0;
    end else begin
      progress <= progress_next;
    end
  end

endmodule

// File: rtl/pattern_matcher.sv
// Multi-pattern byte-sequence detector feeding the LaserDrop control FSM.
// Define PATTERN_MATCHER_TIMEOUT_EN to build the inter-byte gap timeout.
module pattern_matcher
  import pattern_matcher_pkg::*;
#(
  parameter int NUM_SEQ     = DEF_NUM_SEQ,
  parameter int SEQ_BYTES   = DEF_SEQ_BYTES,
  parameter int BYTE_W      = DEF_BYTE_W,
  parameter int GAP_TIMEOUT = DEF_GAP_TIMEOUT
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      en,
  input  logic                                      clear,
  input  logic                                      data_valid,
  input  logic [BYTE_W-1:0]                         data_in,
  input  logic [NUM_SEQ-1:0][SEQ_BYTES*BYTE_W-1:0]  seq,
  input  logic [NUM_SEQ-1:0]                        seq_mask,
  output logic [NUM_SEQ-1:0]                        saw_seq,
  output logic [((NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1)-1:0] seq_index,
  output logic                                      match,
  output logic                                      partial
);

  localparam int IDX_W = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1;

  logic               accept;
  logic               drop;
  logic [NUM_SEQ-1:0] complete;
  logic [NUM_SEQ-1:0] active_next;
  logic [IDX_W-1:0]   first_idx;

  assign accept = en & data_valid & ~clear;

`ifdef PATTERN_MATCHER_TIMEOUT_EN
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

  logic [GAP_W-1:0] gap_cnt;
  logic             idle_tick;

  // Progress is dropped on the same edge the counter reaches the limit,
  // so a byte arriving in that cycle is still processed normally.
  assign idle_tick = en & ~clear & ~data_valid & partial;
  assign drop      = idle_tick & (gap_cnt == GAP_W'(GAP_TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gap_cnt <= '0;
    end else if (clear || accept) begin
      gap_cnt <= '0;
    end else if (idle_tick && (gap_cnt != GAP_W'(GAP_TIMEOUT))) begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end
`else
  assign drop = 1'b0;
`endif

  for (genvar i = 0; i < NUM_SEQ; i++) begin : g_lane
    pattern_lane #(
      .SEQ_BYTES (SEQ_BYTES),
      .BYTE_W    (BYTE_W)
    ) u_lane (
      .clock       (clock),
      .reset       (reset),
      .enable      (seq_mask[i]),
      .accept      (accept),
      .flush       (clear | drop),
      .data_in     (data_in),
      .pattern     (seq[i]),
      .complete    (complete[i]),
      .active_next (active_next[i])
    );
  end

  // Lowest completing lane wins the encoded index
  always_comb begin
    first_idx = '0;
    for (int i = NUM_SEQ - 1; i >= 0; i--) begin
      if (complete[i]) begin
        first_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      saw_seq   <= '0;
      match     <= 1'b0;
      seq_index <= '0;
      partial   <= 1'b0;
    end else begin
      saw_seq   <= complete;
      match     <= |complete;
      seq_index <= first_idx;
      partial   <= |active_next;
    end
  end

endmodule

// File: tb/tb_pattern_matcher.sv
// Self-checking bench for pattern_matcher: directed test-plan steps followed by
// randomized traffic compared against a rule-level reference model.
module tb_pattern_matcher;

  localparam int NS = 4;
  localparam int SB = 4;
  localparam int GT = 64;

  logic             clock;
  logic             reset;
  logic             en;
  logic             clear;
  logic             data_valid;
  logic [7:0]       data_in;
  logic [NS-1:0][31:0] seq;
  logic [NS-1:0]    seq_mask;
  logic [NS-1:0]    saw_seq;
  logic [1:0]       seq_index;
  logic             match;
  logic             partial;

  int checks = 0;
  int errors = 0;

  int         prog [NS];
  int         gap;
  logic [3:0] exp_saw;
  logic [1:0] exp_idx;
  logic       exp_match;
  logic       exp_partial;

  pattern_matcher #(
    .NUM_SEQ     (NS),
    .SEQ_BYTES   (SB),
    .BYTE_W      (8),
    .GAP_TIMEOUT (GT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .clear      (clear),
    .data_valid (data_valid),
    .data_in    (data_in),
    .seq        (seq),
    .seq_mask   (seq_mask),
    .saw_seq    (saw_seq),
    .seq_index  (seq_index),
    .match      (match),
    .partial    (partial)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] pat_byte(input int lane, input int k);
    logic [31:0] word;
    word = seq[lane];
    return word[(SB-1-k)*8 +: 8];
  endfunction

  task automatic model_reset;
    for (int i = 0; i < NS; i++) prog[i] = 0;
    gap         = 0;
    exp_saw     = '0;
    exp_idx     = '0;
    exp_match   = 1'b0;
    exp_partial = 1'b0;
  endtask

  // Reference: each lane is "how many leading pattern bytes have been seen"
  task automatic model_step(input logic e, input logic dv, input logic clr,
                            input logic [7:0] din);
    bit any_before;
    any_before = 0;
    for (int i = 0; i < NS; i++) if (prog[i] > 0) any_before = 1;
    exp_saw = '0;
    if (clr) begin
      for (int i = 0; i < NS; i++) prog[i] = 0;
      gap = 0;
    end else if (e && dv) begin
      gap = 0;
      for (int i = 0; i < NS; i++) begin
        if (din == pat_byte(i, prog[i])) begin
          if (prog[i] == SB - 1) begin
            exp_saw[i] = 1'b1;
            prog[i] = 0;
          end else begin
            prog[i] = prog[i] + 1;
          end
        end else begin
          prog[i] = (din == pat_byte(i, 0)) ? 1 : 0;
        end
        if (!seq_mask[i]) exp_saw[i] = 1'b0;
      end
    end else if (e && any_before) begin
`ifdef PATTERN_MATCHER_TIMEOUT_EN
      if (gap < GT) gap = gap + 1;
      if (gap == GT) for (int i = 0; i < NS; i++) prog[i] = 0;
`endif
    end
    for (int i = 0; i < NS; i++) if (!seq_mask[i]) prog[i] = 0;
    exp_match = (exp_saw != '0);
    exp_idx   = '0;
    for (int i = NS - 1; i >= 0; i--) if (exp_saw[i]) exp_idx = 2'(i);
    exp_partial = 1'b0;
    for (int i = 0; i < NS; i++) if (prog[i] > 0) exp_partial = 1'b1;
  endtask

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_output;
    check_val("saw_seq",   {4'h0, saw_seq},   {4'h0, exp_saw});
    check_val("match",     {7'h0, match},     {7'h0, exp_match});
    check_val("seq_index", {6'h0, seq_index}, {6'h0, exp_idx});
    check_val("partial",   {7'h0, partial},   {7'h0, exp_partial});
  endtask

  // Called at a falling edge; returns at the next falling edge after checking
  task automatic apply_stimulus(input logic e, input logic dv, input logic clr,
                                input logic [7:0] din);
    en         = e;
    data_valid = dv;
    clear      = clr;
    data_in    = din;
    @(posedge clock);
    model_step(e, dv, clr, din);
    @(negedge clock);
    check_output();
  endtask

  task automatic feed(input logic [7:0] b);
    apply_stimulus(1'b1, 1'b1, 1'b0, b);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic load_defaults;
    seq[0] = 32'hc1c2c3c4;
    seq[1] = 32'h51525354;
    seq[2] = 32'hd1d2d3d4;
    seq[3] = 32'ha1a2a3a4;
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'h00);
  endtask

  function automatic logic [7:0] rand_sym();
    return ($urandom_range(0, 19) == 0) ? 8'h55 : 8'(8'h10 + $urandom_range(0, 2));
  endfunction

  initial begin
    reset      = 1'b0;
    en         = 1'b0;
    clear      = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    seq_mask   = 4'hF;
    seq[0] = 32'hc1c2c3c4;
    seq[1] = 32'h51525354;
    seq[2] = 32'hd1d2d3d4;
    seq[3] = 32'ha1a2a3a4;
    model_reset();

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check_val("rst_saw",     {4'h0, saw_seq},   8'h00);
    check_val("rst_match",   {7'h0, match},     8'h00);
    check_val("rst_index",   {6'h0, seq_index}, 8'h00);
    check_val("rst_partial", {7'h0, partial},   8'h00);
    reset = 1'b1;

    // START pattern, pulse exactly one cycle after the last byte
    load_defaults();
    feed(8'hc1); feed(8'hc2); feed(8'hc3);
    check_val("start_pre", {4'h0, saw_seq}, 8'h00);
    feed(8'hc4);
    check_val("start_saw",   {4'h0, saw_seq},   8'h01);
    check_val("start_index", {6'h0, seq_index}, 8'h00);
    idle(1);
    check_val("start_pulse_width", {4'h0, saw_seq}, 8'h00);

    // Restart on repeated leading byte
    feed(8'hc1); feed(8'hc1); feed(8'hc2); feed(8'hc3); feed(8'hc4);
    check_val("restart_saw", {4'h0, saw_seq}, 8'h01);
    idle(1);

    // Two identical patterns complete together, lowest index reported
    seq[0] = 32'haabbccdd;
    seq[2] = 32'haabbccdd;
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'h00);
    feed(8'haa); feed(8'hbb); feed(8'hcc); feed(8'hdd);
    check_val("dual_saw",   {4'h0, saw_seq},   8'h05);
    check_val("dual_index", {6'h0, seq_index}, 8'h00);
    check_val("dual_match", {7'h0, match},     8'h01);

    // Inter-byte gap
    load_defaults();
    feed(8'hd1); feed(8'hd2);
    idle(GT - 1);
    check_val("gap_partial_before", {7'h0, partial}, 8'h01);
    idle(1);
`ifdef PATTERN_MATCHER_TIMEOUT_EN
    check_val("gap_partial_after", {7'h0, partial}, 8'h00);
`else
    check_val("gap_partial_after", {7'h0, partial}, 8'h01);
`endif
    feed(8'hd3); feed(8'hd4);
`ifdef PATTERN_MATCHER_TIMEOUT_EN
    check_val("gap_saw", {4'h0, saw_seq}, 8'h00);
`else
    check_val("gap_saw", {4'h0, saw_seq}, 8'h04);
`endif
    idle(1);

    // Reset mid-pattern abandons progress
    feed(8'h51); feed(8'h52); feed(8'h53);
    reset = 1'b0;
    model_reset();
    #2;
    check_val("midrst_partial", {7'h0, partial}, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    feed(8'h54);
    check_val("midrst_saw", {4'h0, saw_seq}, 8'h00);

    // Masked lane never matches
    seq_mask = 4'b1101;
    feed(8'h51); feed(8'h52); feed(8'h53); feed(8'h54);
    check_val("mask_saw",   {4'h0, saw_seq}, 8'h00);
    check_val("mask_match", {7'h0, match},   8'h00);
    seq_mask = 4'hF;

    // en low: bytes ignored
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hc1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hc2);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hc3);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hc4);
    check_val("en_partial", {7'h0, partial}, 8'h00);
    check_val("en_saw",     {4'h0, saw_seq}, 8'h00);

    // Randomized traffic on a small alphabet to force overlaps and shared prefixes
    for (int i = 0; i < NS; i++) seq[i] = {rand_sym(), rand_sym(), rand_sym(), rand_sym()};
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'h00);
    for (int step = 0; step < 3000; step++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 15) begin
        for (int i = 0; i < NS; i++) begin
          if ($urandom_range(0, 1) == 1) seq[i] = {rand_sym(), rand_sym(), rand_sym(), rand_sym()};
        end
        if ($urandom_range(0, 3) == 0) seq[1] = seq[0];
        apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, rand_sym());
      end else if (r < 30) begin
        seq_mask = 4'($urandom_range(0, 15));
        apply_stimulus(1'b1, 1'b1, 1'b0, rand_sym());
      end else if (r < 40) begin
        idle(int'($urandom_range(GT - 3, GT + 3)));
      end else if (r < 120) begin
        apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, rand_sym());
      end else begin
        apply_stimulus(1'b1, 1'($urandom_range(0, 9) < 7), 1'b0, rand_sym());
      end
    end

    $display("[TB] directed and random phases done");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
